// File: rtl/reqack_fifo.sv
// Elastic req/ack buffer: initiator toward the upstream responder, responder toward the
// downstream initiator, with a circular store of depth words in between.
module reqack_fifo #(
    parameter int unsigned  data_width = 32,
    parameter int unsigned  depth      = 4,
    localparam int unsigned ptr_width  = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [ptr_width:0]    level,
    output logic                  overflow
);

    localparam logic [ptr_width:0] full_level = (ptr_width + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;
    logic [ptr_width:0]    level_next;
    logic                  req_l_next;

    always_comb begin
        full       = (level == full_level);
        wr_en      = ack_l && !full;
        // ack_r is forced low for a cycle after every read; the registered level gates reads,
        // so a word written this edge is not visible to the reader until the next one.
        rd_en      = req_r && !ack_r && (level != '0);
        level_next = level;
        if (wr_en && !rd_en) begin
            level_next = level + 1'b1;
        end else if (rd_en && !wr_en) begin
            level_next = level - 1'b1;
        end
        // A raised request is only re-evaluated once the upstream word has arrived.
        req_l_next = req_l;
        if (ack_l || !req_l) begin
            req_l_next = (level_next < full_level);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_l    <= 1'b0;
            ack_r    <= 1'b0;
            dout     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            req_l <= req_l_next;
            level <= level_next;
            ack_r <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ack_l && full) begin
                overflow <= 1'b1;
            end
            if (rd_en) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_reqack_fifo.sv
// Directed and stall-randomised checks of reqack_fifo with depth 4, 32-bit words.
module tb_reqack_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_l;
    logic        ack_l;
    logic [31:0] din;
    logic        req_r;
    logic        ack_r;
    logic [31:0] dout;
    logic [2:0]  level;
    logic        overflow;

    logic        prod_ack   = 1'b0;
    logic [31:0] prod_din   = '0;
    logic        man_ack    = 1'b0;
    logic [31:0] man_din    = '0;
    logic        man_req    = 1'b0;
    logic        rand_req   = 1'b0;
    logic        rand_mode  = 1'b0;
    logic        prod_en    = 1'b0;
    logic        mon_en     = 1'b0;
    logic        period_chk = 1'b0;

    int prod_val   = 0;
    int prod_limit = 0;
    int prod_stall = 0;
    int last_go    = 0;
    int cons_exp   = 0;
    int cons_cnt   = 0;
    int max_lvl    = 0;
    int cyc        = 0;
    int total      = 0;
    int bad        = 0;
    int t0         = 0;

    assign ack_l = prod_ack | man_ack;
    assign din   = prod_ack ? prod_din : man_din;
    assign req_r = rand_mode ? rand_req : man_req;

    reqack_fifo #(
        .data_width(32),
        .depth     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_l   (req_l),
        .ack_l   (ack_l),
        .din     (din),
        .req_r   (req_r),
        .ack_r   (ack_r),
        .dout    (dout),
        .level   (level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        @(posedge clk); #1;
        man_ack = 1'b1;
        man_din = v;
        @(posedge clk); #1;
        man_ack = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_r && n < 20);
        check({tag, "_ack"}, 32'(ack_r), 1);
        check(tag, dout, v);
    endtask

    task automatic wait_level(input string tag, input int lv);
        int n = 0;
        while (int'(level) != lv && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(level), 32'(lv));
    endtask

    task automatic wait_cons(input int cnt, input int budget);
        int n = 0;
        while (cons_cnt < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cons_count", 32'(cons_cnt), 32'(cnt));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Upstream responder: samples req_l & ~ack_l before edge N, pulses ack_l after edge N.
    initial begin : producer
        logic go;
        forever begin
            @(negedge clk);
            go = prod_en && rst && req_l && !ack_l && (prod_val < prod_limit)
                 && (int'($urandom_range(99)) >= prod_stall);
            @(posedge clk); #1;
            prod_ack = go;
            if (go) begin
                if (period_chk && prod_val > 3) check("ackl_period", 32'(cyc - last_go), 2);
                last_go  = cyc;
                prod_din = 32'(prod_val);
                prod_val++;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rand_req = ($urandom_range(99) >= 30);
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (ack_r) begin
                check("order", dout, 32'(cons_exp));
                cons_exp++;
                cons_cnt++;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
    end

    initial begin
        // Power-on reset
        #1 rst = 1'b0;
        #1;
        check("rst_req_l", 32'(req_l), 0);
        check("rst_ack_r", 32'(ack_r), 0);
        check("rst_dout", dout, 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("rel_req_l_pre", 32'(req_l), 0);
        @(posedge clk); #1;
        check("rel_req_l", 32'(req_l), 1);

        // Fill with the consumer idle, then drain
        prod_val   = 0;
        prod_limit = 100;
        prod_stall = 0;
        prod_en    = 1'b1;
        wait_level("fill_level", 4);
        check("fill_req_l", 32'(req_l), 0);
        repeat (6) @(negedge clk);
        check("fill_req_l_hold", 32'(req_l), 0);
        check("fill_pulses", 32'(prod_val), 4);
        check("fill_level_hold", 32'(level), 4);
        prod_en = 1'b0;
        @(posedge clk); #1;
        man_req = 1'b1;
        pop_expect("drain0", 0);
        t0 = cyc;
        check("drain_req_l", 32'(req_l), 1);
        for (int i = 1; i < 4; i++) begin
            pop_expect("drain", 32'(i));
            check("drain_gap", 32'(cyc - t0), 2);
            t0 = cyc;
        end
        man_req = 1'b0;
        check("drain_level", 32'(level), 0);

        // Write and read on the same edge at level 2
        push(32'd10);
        push(32'd11);
        @(negedge clk);
        check("sim_pre_level", 32'(level), 2);
        @(posedge clk); #1;
        man_ack = 1'b1;
        man_din = 32'd12;
        man_req = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        @(negedge clk);
        check("sim_level", 32'(level), 2);
        check("sim_ack_r", 32'(ack_r), 1);
        check("sim_dout", dout, 32'd10);
        pop_expect("sim_pop1", 32'd11);
        pop_expect("sim_pop2", 32'd12);
        man_req = 1'b0;
        check("sim_end_level", 32'(level), 0);

        // Overflow drop
        for (int i = 0; i < 4; i++) push(32'(20 + i));
        push(32'hDEAD);
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_level", 32'(level), 4);
        check("ovf_req_l", 32'(req_l), 0);
        man_req = 1'b1;
        for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 32'(20 + i));
        man_req = 1'b0;
        repeat (4) @(negedge clk);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_no_extra", 32'(ack_r), 0);
        check("ovf_end_level", 32'(level), 0);

        // Asynchronous reset mid-stream at level 3
        push(32'd30);
        push(32'd31);
        push(32'd32);
        @(negedge clk);
        check("mid_pre_level", 32'(level), 3);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_req_l", 32'(req_l), 0);
        check("mid_ack_r", 32'(ack_r), 0);
        check("mid_level", 32'(level), 0);
        check("mid_overflow", 32'(overflow), 0);
        check("mid_dout", dout, 0);
        man_ack = 1'b1;
        man_din = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        man_ack = 1'b0;
        rst     = 1'b1;
        #1;
        check("mid_rel_level", 32'(level), 0);
        check("mid_rel_req_pre", 32'(req_l), 0);
        @(posedge clk); #1;
        check("mid_rel_req_l", 32'(req_l), 1);

        // Pass-through, consumer always requesting
        cons_exp   = 0;
        cons_cnt   = 0;
        prod_val   = 0;
        prod_limit = 100;
        prod_stall = 0;
        period_chk = 1'b1;
        man_req    = 1'b1;
        mon_en     = 1'b1;
        prod_en    = 1'b1;
        wait_cons(100, 2000);
        period_chk = 1'b0;
        repeat (5) @(negedge clk);
        check("pt_count", 32'(cons_cnt), 100);
        check("pt_overflow", 32'(overflow), 0);
        check("pt_level", 32'(level), 0);

        // Random stalls on both sides
        mon_en  = 1'b0;
        prod_en = 1'b0;
        man_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        cons_exp   = 0;
        cons_cnt   = 0;
        prod_val   = 0;
        prod_limit = 5000;
        prod_stall = 30;
        max_lvl    = 0;
        rand_mode  = 1'b1;
        mon_en     = 1'b1;
        prod_en    = 1'b1;
        wait_cons(5000, 60000);
        repeat (10) @(negedge clk);
        check("rand_count", 32'(cons_cnt), 5000);
        check("rand_max_level_ok", 32'(max_lvl <= 4), 1);
        check("rand_overflow", 32'(overflow), 0);
        check("rand_level", 32'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
